hs_receiver: RTL
================

# hs_receiver

Receive end of the four-phase req/ack handshake used to move an N-bit word across a clock-domain boundary. The transmit side asserts `req_in` with `data_in` held stable. This block synchronizes `req_in` into its local clock `clk_t` and captures the word. It presents the word downstream with a valid/ready handshake, then returns `ack_out` to the sender.

## Interface
- `N`, default 8: data word width.
- `SYNC_STAGES`, default 2: flip-flop stages on the `req_in` synchronizer. Legal range is ≥2.
- `clk_t`, input, 1: local clock.
- `rst`, input, 1: reset, asynchronous, active-low.
- `req_in`, input, 1: request from the sender domain. Asynchronous to `clk_t`.
- `data_in`, input, N: word from the sender. Stable from `req_in` rise until `ack_out` is seen high by the sender.
- `ready`, input, 1: downstream can accept `data_out`.
- `data_out`, output, N: captured word.
- `valid`, output, 1: `data_out` holds an undelivered word.
- `ack_out`, output, 1: acknowledge to the sender. Driven straight from a flop, no logic after it.
- `xfer_cnt`, output, 16: count of completed downstream transfers.
- `proto_err`, output, 1: sticky flag for a protocol violation.

## Operation
- `req_in` passes through `SYNC_STAGES` flops. The last stage is `req_s`. No other logic touches raw `req_in`.
- The FSM has three states: IDLE, OUT and ACK. All outputs are registered.
- **IDLE** (`valid`=0, `ack_out`=0):
  - If `req_s`=1: load `data_in` into `data_out`, set `valid`=1, go to OUT.
- **OUT** (`valid`=1, `ack_out`=0):
  - If `ready`=1: clear `valid`, set `ack_out`=1, increment `xfer_cnt`, go to ACK.
  - Otherwise: hold `data_out` and `valid`.
  - If `req_s`=0 is seen in OUT: set `proto_err`=1. The FSM stays in OUT and delivers the word normally.
- **ACK** (`valid`=0, `ack_out`=1):
  - If `req_s`=0: clear `ack_out`, go to IDLE.
  - While `req_s` stays 1: remain in ACK. No new capture happens until the four-phase cycle closes.
- `data_in` is sampled only on the IDLE→OUT transition.
- `data_out` holds its last value in every state except on that load.
- `xfer_cnt` increments on `valid`&`ready` only. It is unsigned, 16 bits, and wraps 0xFFFF→0x0000.
- `proto_err` is cleared only by reset.

## Timing
- Reset values:
  - State = IDLE.
  - All synchronizer flops = 0.
  - `data_out` = 0, `valid` = 0, `ack_out` = 0, `xfer_cnt` = 0, `proto_err` = 0.
- Reset is asynchronous assert, synchronous release to `clk_t` (handled externally).
- Take edge 1 as the first `clk_t` edge that samples `req_in`=1.
  - `req_s`=1 after edge `SYNC_STAGES`.
  - `valid`=1 and `data_out` loaded after edge `SYNC_STAGES`+1.
- If `ready`=1 at the first edge where `valid`=1, then after that edge: `valid`=0, `ack_out`=1, `xfer_cnt`+1.
  - Each cycle `ready` is low adds one cycle of latency.
- Take edge 1 as the first edge that samples `req_in`=0 while in ACK.
  - `ack_out`=0 after edge `SYNC_STAGES`+1.
  - The FSM is in IDLE and can accept a new `req_s` on the following edge.
- Minimum full cycle at `SYNC_STAGES`=2 with `ready` tied high is about 6 `clk_t` cycles from `req` rise to `ack` fall, plus the sender's synchronizer delay.
- `valid` and `ready` may both be high in the same cycle. The transfer happens on that edge.
- Reset during OUT or ACK:
  - All state returns to reset values and the undelivered word is dropped.
  - If `req_in` is still high after reset, the same word is captured again as a new transfer. This duplicate delivery is the defined behaviour.
- A `req_in` glitch shorter than one `clk_t` period is not guaranteed to be seen. If it is seen, it causes one capture.

## Test plan
- **Single word:** `N`=8, `ready`=1. Raise `req_in` with `data_in`=0xA5 and hold until `ack_out`=1, then drop `req_in`.
  - `data_out`=0xA5 and `valid` high for exactly 1 cycle, `SYNC_STAGES`+1 edges after `req` is sampled.
  - `ack_out` rises the next edge and falls `SYNC_STAGES`+1 edges after `req` falls.
  - `xfer_cnt`=1.
- **Backpressure:** hold `ready`=0 for 5 cycles after `valid` rises, `data_in`=0x3C.
  - `valid` stays 1 and `data_out` stays 0x3C for all 5 cycles.
  - `ack_out` stays 0 until the cycle after `ready`=1.
- **Back-to-back:** send 0x00, 0xFF, 0x5A with a sender model that closes each four-phase cycle.
  - Outputs arrive in order with no duplicates.
  - `ack_out` never rises while `valid`=1.
- **Counter wrap:** preload via 65535 transfers (or force `xfer_cnt` to 0xFFFF), then do one transfer.
  - `xfer_cnt`=0x0000.
  - `proto_err` stays 0.
- **Protocol violation:** drop `req_in` while in OUT with `ready`=0.
  - `proto_err`=1 from the next sync-delayed cycle.
  - The word is still delivered when `ready`=1.
  - `proto_err` stays 1 until `rst`=0.
- **Reset mid-transfer:** assert `rst`=0 in ACK while `req_in`=1, then release.
  - All outputs return to 0 immediately.
  - After release, the same `data_in` word is re-delivered with `valid`=1 and `xfer_cnt`=1.

Source files
------------

// File: rtl/hs_receiver.sv
// hs_receiver: receive side of a four-phase req/ack crossing. The request is
// synchronized into clk_t, the word is captured once per handshake, offered
// downstream on valid/ready, and ack_out is returned to the sender.
`timescale 1ns/1ps
module hs_receiver #(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk_t,
    input  logic         rst,
    input  logic         req_in,
    input  logic [N-1:0] data_in,
    input  logic         ready,
    output logic [N-1:0] data_out,
    output logic         valid,
    output logic         ack_out,
    output logic [15:0]  xfer_cnt,
    output logic         proto_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OUT  = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_req_s;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [N-1:0]           r_data;
    logic [N-1:0]           w_data_nxt;
    logic                   r_valid;
    logic                   w_valid_nxt;
    logic                   r_ack;
    logic                   w_ack_nxt;
    logic [15:0]            r_xfer_cnt;
    logic [15:0]            w_cnt_nxt;
    logic                   r_err;
    logic                   w_err_nxt;

    // Only this shift chain ever looks at the raw asynchronous request.
    always_ff @(posedge clk_t or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], req_in};
        end
    end

    assign w_req_s = r_sync[SYNC_STAGES-1];

    // Next-state and next-output decode; every register holds unless an arm changes it.
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_ack_nxt   = r_ack;
        w_cnt_nxt   = r_xfer_cnt;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                if (w_req_s) begin
                    w_data_nxt  = data_in;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                // Sender withdrew its request before we acknowledged: flag it,
                // but still deliver the word we already hold.
                if (!w_req_s) begin
                    w_err_nxt = 1'b1;
                end
                if (r_valid && ready) begin
                    w_valid_nxt = 1'b0;
                    w_ack_nxt   = 1'b1;
                    w_cnt_nxt   = r_xfer_cnt + 16'd1;
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                // Wait for the sender to close the four-phase cycle.
                if (!w_req_s) begin
                    w_ack_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_ack_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any undelivered word.
    always_ff @(posedge clk_t or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_ack      <= 1'b0;
            r_xfer_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_data     <= w_data_nxt;
            r_valid    <= w_valid_nxt;
            r_ack      <= w_ack_nxt;
            r_xfer_cnt <= w_cnt_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign data_out  = r_data;
    assign valid     = r_valid;
    assign ack_out   = r_ack;
    assign xfer_cnt  = r_xfer_cnt;
    assign proto_err = r_err;

endmodule
